// File: rtl/dbg_mem_arbiter_pkg.sv
// dbg_mem_arbiter_pkg: shared memory-port definitions for the crv32 debug arbiter
// (state encodings, abort data pattern, address/data/strobe widths).
package dbg_mem_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int HOLD_W = 8;

  // Read data returned to the requester when a stalled transfer is aborted.
  localparam logic [DATA_W-1:0] ABORT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_XFER = 2'd1,
    ST_DBG_XFER = 2'd2
  } arb_state_e;
endpackage

// File: rtl/dbg_req_detect.sv
// dbg_req_detect: turns the level-driven debug port into single requests.
// A request is pending after dbg_mem_op rises or while the request fields
// differ from the last accepted ones; dropping dbg_mem_op cancels it.
module dbg_req_detect
  import dbg_mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_mem_op,
  input  logic [STRB_W-1:0] dbg_wren,
  input  logic [ADDR_W-1:0] dbg_adr,
  input  logic [DATA_W-1:0] dbg_do,
  input  logic              accept,
  output logic              pending
);
  localparam int REQ_W = STRB_W + ADDR_W + DATA_W;

  logic             op_q, op_d;
  logic             pend_q, pend_d;
  logic [REQ_W-1:0] cap_q, cap_d;
  logic [REQ_W-1:0] req_now;

  assign req_now = {dbg_wren, dbg_adr, dbg_do};

  // Pending flag: cancel on op low, clear and capture on accept, set on rise or change
  always_comb begin
    op_d   = dbg_mem_op;
    cap_d  = cap_q;
    pend_d = pend_q;
    if (!dbg_mem_op) begin
      pend_d = 1'b0;
    end else if (accept) begin
      pend_d = 1'b0;
      cap_d  = req_now;
    end else if (!op_q || (req_now != cap_q)) begin
      pend_d = 1'b1;
    end
  end

  // Detector state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= 1'b0;
      pend_q <= 1'b0;
      cap_q  <= '0;
    end else begin
      op_q   <= op_d;
      pend_q <= pend_d;
      cap_q  <= cap_d;
    end
  end

  // A request still flagged in the cycle dbg_mem_op falls is not served.
  assign pending = pend_q && dbg_mem_op;
endmodule

// File: rtl/dbg_mem_arbiter.sv
// dbg_mem_arbiter: shares the native memory port between picorv32 and the
// debug port. Debug wins and holds the CPU in reset while active.
// Optional stall timeout: define DBG_ARB_TIMEOUT_EN.
module dbg_mem_arbiter
  import dbg_mem_arbiter_pkg::*;
#(
  parameter int unsigned RST_HOLD   = 16,
  parameter int unsigned TMO_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [STRB_W-1:0] cpu_wstrb,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_n_reset,
  input  logic              dbg_mem_op,
  input  logic [STRB_W-1:0] dbg_wren,
  input  logic [ADDR_W-1:0] dbg_adr,
  input  logic [DATA_W-1:0] dbg_do,
  output logic [DATA_W-1:0] dbg_di,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_e        state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] dbg_di_q, dbg_di_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              dbg_pending, accept, done, tmo_hit;
  logic [DATA_W-1:0] rdata_eff;

  dbg_req_detect u_req_detect (
    .clk        (clk),
    .reset      (reset),
    .dbg_mem_op (dbg_mem_op),
    .dbg_wren   (dbg_wren),
    .dbg_adr    (dbg_adr),
    .dbg_do     (dbg_do),
    .accept     (accept),
    .pending    (dbg_pending)
  );

`ifdef DBG_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             dbg_err_q, dbg_err_d;

  // Abort fires on the TMO_CYCLES-th consecutive stalled cycle.
  assign tmo_hit = mem_valid_q && !mem_ready && (tmo_q == TMO_W'(TMO_CYCLES - 1));

  // Stall counter and sticky error flag
  always_comb begin
    tmo_d     = tmo_q;
    dbg_err_d = dbg_err_q;
    if (!mem_valid_q || mem_ready || tmo_hit) tmo_d = '0;
    else                                      tmo_d = tmo_q + TMO_W'(1);
    if (tmo_hit) dbg_err_d = 1'b1;
  end

  // Timeout registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q     <= '0;
      dbg_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      dbg_err_q <= dbg_err_d;
    end
  end

  assign dbg_err = dbg_err_q;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TMO_CYCLES);
  assign tmo_hit    = 1'b0;
  assign dbg_err    = 1'b0;
`endif

  assign done      = mem_valid_q && (mem_ready || tmo_hit);
  assign rdata_eff = tmo_hit ? ABORT_DATA : mem_rdata;

  // CPU reset hold: reload while debug is active, count down afterwards
  always_comb begin
    hold_d = hold_q;
    if (dbg_mem_op)          hold_d = HOLD_W'(RST_HOLD);
    else if (hold_q != '0)   hold_d = hold_q - HOLD_W'(1);
  end

  assign cpu_n_reset = !reset && !dbg_mem_op && (hold_q == '0);
  assign cpu_ready   = !reset && cpu_n_reset && (state_q == ST_CPU_XFER) && done;
  assign cpu_rdata   = cpu_ready ? rdata_eff : '0;

  // Arbiter FSM: pick a requester in IDLE, hold the bus until completion
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    dbg_ack_d   = 1'b0;
    dbg_di_d    = dbg_di_q;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dbg_pending) begin
          accept      = 1'b1;
          state_d     = ST_DBG_XFER;
          mem_valid_d = 1'b1;
          mem_addr_d  = dbg_adr;
          mem_wdata_d = dbg_do;
          mem_wstrb_d = dbg_wren;
        end else if (cpu_valid && cpu_n_reset) begin
          state_d     = ST_CPU_XFER;
          mem_valid_d = 1'b1;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_wstrb_d = cpu_wstrb;
        end
      end
      ST_CPU_XFER, ST_DBG_XFER: begin
        if (done) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          if (state_q == ST_DBG_XFER) begin
            dbg_ack_d = 1'b1;
            if ((mem_wstrb_q == '0) || tmo_hit) dbg_di_d = rdata_eff;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_di_q    <= '0;
      hold_q      <= HOLD_W'(RST_HOLD);
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_di_q    <= dbg_di_d;
      hold_q      <= hold_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_di    = dbg_di_q;
endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// tb_dbg_mem_arbiter: directed vectors for the debug/CPU memory arbiter.
module tb_dbg_mem_arbiter;
  localparam int RST_HOLD = 16;
  localparam int TMO      = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_n_reset;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr, dbg_do, dbg_di;
  logic        dbg_ack, dbg_err;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  dbg_mem_arbiter #(.RST_HOLD(RST_HOLD), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_n_reset(cpu_n_reset),
    .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
    .dbg_di(dbg_di), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: 16 words, ready after mem_lat waiting cycles unless stalled
  logic [31:0] mem [16];
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_strb[$];
  int xfer_cnt = 0;
  int wcnt     = 0;
  int mem_lat  = 1;
  bit mem_stall = 1'b0;

  always @(posedge clk) begin
    #1;
    if (mem_valid && !mem_stall && wcnt >= mem_lat) begin
      mem_ready = 1'b1;
      mem_rdata = mem[mem_addr[5:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      log_addr.push_back(mem_addr);
      log_wdata.push_back(mem_wdata);
      log_strb.push_back(mem_wstrb);
      xfer_cnt++;
      wcnt = 0;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      wcnt = mem_valid ? wcnt + 1 : 0;
    end
  end

  // Event counters sampled on the falling edge
  int ack_cnt = 0, rdy_cnt = 0, nrst_hi = 0, vrise = 0;
  bit mv_prev = 1'b0;
  always @(negedge clk) begin
    if (dbg_ack) ack_cnt++;
    if (cpu_ready) rdy_cnt++;
    if (cpu_n_reset) nrst_hi++;
    if (mem_valid && !mv_prev) vrise++;
    mv_prev = mem_valid;
  end

  typedef struct {
    logic [3:0]  wren;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          exp_x;
    logic [31:0] exp_di;
  } dvec_t;

  task automatic wait_mem_valid(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (mem_valid) break;
      @(negedge clk);
    end
    check(name, 32'(mem_valid), 32'd1);
  endtask

  initial begin
    dvec_t tv[6];
    int a0, x0, r0, v0, n0, rise_at, cnt;
    bit seen;
    logic [31:0] got;

    tv[0] = '{4'hF, 32'h20000, 32'h000107b7, 1, 32'h0};
    tv[1] = '{4'hF, 32'h20004, 32'h0007a023, 1, 32'h0};
    tv[2] = '{4'hF, 32'h20008, 32'h0000006f, 1, 32'h0};
    tv[3] = '{4'h0, 32'h20004, 32'h0,        1, 32'h0007a023};
    tv[4] = '{4'h0, 32'h20008, 32'h0,        1, 32'h0000006f};
    tv[5] = '{4'h0, 32'h20008, 32'h0,        0, 32'h0000006f};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    reset = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    dbg_mem_op = 1'b0; dbg_wren = '0; dbg_adr = '0; dbg_do = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_cpu_n_reset", 32'(cpu_n_reset), 32'd0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rst_dbg_di", dbg_di, 32'd0);
    check("rst_dbg_err", 32'(dbg_err), 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);

    // Debug writes then reads, op held high
    reset = 1'b0;
    n0 = nrst_hi;
    mem_lat = 1;
    for (int v = 0; v < 6; v++) begin
      a0 = ack_cnt; x0 = xfer_cnt;
      dbg_mem_op = 1'b1; dbg_wren = tv[v].wren; dbg_adr = tv[v].adr; dbg_do = tv[v].wdat;
      repeat ((v < 3) ? 1000 : 50) @(negedge clk);
      check($sformatf("v%0d_acks", v), 32'(ack_cnt - a0), 32'(tv[v].exp_x));
      check($sformatf("v%0d_xfers", v), 32'(xfer_cnt - x0), 32'(tv[v].exp_x));
      if (tv[v].exp_x == 1 && xfer_cnt > x0) begin
        check($sformatf("v%0d_addr", v), log_addr[x0], tv[v].adr);
        check($sformatf("v%0d_strb", v), 32'(log_strb[x0]), 32'(tv[v].wren));
        if (tv[v].wren != 4'h0) check($sformatf("v%0d_wdata", v), log_wdata[x0], tv[v].wdat);
      end
      check($sformatf("v%0d_dbg_di", v), dbg_di, tv[v].exp_di);
    end
    check("nrst_low_during_dbg", 32'(nrst_hi - n0), 32'd0);

    // Release debug: CPU held for RST_HOLD cycles, then first fetch
    x0 = xfer_cnt; r0 = rdy_cnt; rise_at = -1;
    mem_lat = 2;
    dbg_mem_op = 1'b0;
    cpu_valid = 1'b1; cpu_addr = 32'h20000; cpu_wstrb = 4'h0; cpu_wdata = '0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (cpu_n_reset) begin rise_at = j; break; end
    end
    check("nrst_rise_cycles", 32'(rise_at), 32'(RST_HOLD));
    check("cpu_ignored_in_reset", 32'(xfer_cnt - x0), 32'd0);
    seen = 1'b0; got = '0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (cpu_ready) begin seen = 1'b1; got = cpu_rdata; cpu_valid = 1'b0; break; end
    end
    cpu_valid = 1'b0;
    check("cpu_ready_seen", 32'(seen), 32'd1);
    check("cpu_fetch_rdata", got, 32'h000107b7);
    repeat (10) @(negedge clk);
    check("cpu_ready_pulses", 32'(rdy_cnt - r0), 32'd1);
    check("cpu_fetch_xfers", 32'(xfer_cnt - x0), 32'd1);

    // Collision: debug raised while CPU transfer waits 5 cycles
    x0 = xfer_cnt; a0 = ack_cnt; v0 = vrise;
    mem_lat = 5;
    cpu_valid = 1'b1; cpu_addr = 32'h20008; cpu_wstrb = 4'h0;
    wait_mem_valid("coll_cpu_start", 20);
    dbg_mem_op = 1'b1; dbg_wren = 4'h0; dbg_adr = 32'h20004; dbg_do = '0;
    cpu_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("coll_xfers", 32'(xfer_cnt - x0), 32'd2);
    check("coll_separate_valids", 32'(vrise - v0), 32'd2);
    if (xfer_cnt - x0 >= 2) begin
      check("coll_first_is_cpu", log_addr[x0], 32'h20008);
      check("coll_second_is_dbg", log_addr[x0+1], 32'h20004);
    end
    check("coll_dbg_acks", 32'(ack_cnt - a0), 32'd1);
    check("coll_dbg_di", dbg_di, 32'h0007a023);

    // Reset while a debug transfer is stalled
    mem_stall = 1'b1; mem_lat = 1;
    a0 = ack_cnt;
    dbg_adr = 32'h20000;
    wait_mem_valid("rstx_start", 20);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstx_mem_valid", 32'(mem_valid), 32'd0);
    check("rstx_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rstx_cpu_n_reset", 32'(cpu_n_reset), 32'd0);
    @(negedge clk);
    check("rstx_no_ack", 32'(ack_cnt - a0), 32'd0);
    mem_stall = 1'b0;
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("rstx_reissue_ack", 32'(ack_cnt - a0), 32'd1);
    check("rstx_reissue_di", dbg_di, 32'h000107b7);

    // Stall with mem_ready held low
    mem_stall = 1'b1;
    a0 = ack_cnt;
    dbg_adr = 32'h20008;
    wait_mem_valid("tmo_start", 20);
`ifdef DBG_ARB_TIMEOUT_EN
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (!mem_valid) break;
      cnt++;
      @(negedge clk);
    end
    check("tmo_valid_cycles", 32'(cnt), 32'(TMO));
    check("tmo_ack", 32'(dbg_ack), 32'd1);
    check("tmo_dbg_di", dbg_di, 32'hDEADBEEF);
    check("tmo_dbg_err", 32'(dbg_err), 32'd1);
`else
    cnt = 0;
    repeat (40) @(negedge clk);
    check("stall_still_valid", 32'(mem_valid), 32'd1);
    check("stall_no_ack", 32'(ack_cnt - a0 + cnt), 32'd0);
    check("stall_dbg_err", 32'(dbg_err), 32'd0);
`endif
    reset = 1'b1;
    mem_stall = 1'b0;
    dbg_mem_op = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
